// File: rtl/ps2_key_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_queue
// Purpose  : PS/2 scan-code decoder (make/break, E0, Pause) with modifier
//            tracking and a first-word-fall-through event FIFO.
//            Optional KBD_REPEAT_FILTER_EN suppresses typematic repeats.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_queue #(
   parameter int DEPTH      = 16,
   parameter int MOD_EVENTS = 1
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic [7:0]               kb_data,
   input  logic                     kb_ready,
   output logic                     kb_nextdata_n,
   output logic                     ev_valid,
   output logic [7:0]               ev_code,
   output logic                     ev_ext,
   output logic                     ev_brk,
   output logic [4:0]               ev_mods,
   input  logic                     ev_rd,
   output logic [$clog2(DEPTH):0]   ev_count,
   output logic                     overflow,
   output logic                     shift,
   output logic                     ctrl,
   output logic                     alt,
   output logic                     caps
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GOT_E0   = 3'd1,
      GOT_F0   = 3'd2,
      GOT_E0F0 = 3'd3,
      SKIP     = 3'd4
   } state_t;

   state_t     state, state_nx;
   logic [2:0] skip_cnt, skip_cnt_nx;
   logic       accept;
   logic       done, pause_ev, ext, brk;
   logic [7:0] code;
   logic       fake, valid_ev, is_mod, repeat_ev, push_req;
   logic [4:0] mods, mods_nx;   // {caps, alt, ctrl, rshift, lshift}

   assign accept = kb_ready & kb_nextdata_n;

   always_comb begin
      state_nx    = state;
      skip_cnt_nx = skip_cnt;
      done        = 1'b0;
      pause_ev    = 1'b0;
      code        = kb_data;
      ext         = 1'b0;
      brk         = 1'b0;
      if (accept) begin
         case (state)
            IDLE: begin
               case (kb_data)
                  8'hE0: state_nx = GOT_E0;
                  8'hF0: state_nx = GOT_F0;
                  8'hE1: begin
                     state_nx    = SKIP;
                     skip_cnt_nx = 3'd7;
                  end
                  8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nx = IDLE;
                  default: done = 1'b1;
               endcase
            end
            GOT_E0: begin
               if (kb_data == 8'hF0) begin
                  state_nx = GOT_E0F0;
               end else begin
                  done     = 1'b1;
                  ext      = 1'b1;
                  state_nx = IDLE;
               end
            end
            GOT_F0: begin
               done     = 1'b1;
               brk      = 1'b1;
               state_nx = IDLE;
            end
            GOT_E0F0: begin
               done     = 1'b1;
               ext      = 1'b1;
               brk      = 1'b1;
               state_nx = IDLE;
            end
            SKIP: begin
               skip_cnt_nx = skip_cnt - 3'd1;
               if (skip_cnt == 3'd1) begin
                  done     = 1'b1;
                  pause_ev = 1'b1;
                  code     = 8'hE1;
                  state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign fake     = done & ext & ((code == 8'h12) | (code == 8'h59));
   assign valid_ev = done & ~fake;
   assign is_mod   = ~pause_ev & ((code == 8'h12) | (code == 8'h59) |
                     (code == 8'h14) | (code == 8'h11) | (code == 8'h58));

`ifdef KBD_REPEAT_FILTER_EN
   logic       held;
   logic [8:0] held_key;

   assign repeat_ev = valid_ev & ~brk & ~pause_ev & held & (held_key == {ext, code});

   always_ff @(posedge clk) begin
      if (clr) begin
         held     <= 1'b0;
         held_key <= 9'd0;
      end else if (valid_ev && !pause_ev) begin
         if (!brk) begin
            held     <= 1'b1;
            held_key <= {ext, code};
         end else if (held && held_key == {ext, code}) begin
            held <= 1'b0;
         end
      end
   end
`else
   assign repeat_ev = 1'b0;
`endif

   always_comb begin
      mods_nx = mods;
      if (valid_ev && !pause_ev) begin
         case (code)
            8'h12: mods_nx[0] = ~brk;
            8'h59: mods_nx[1] = ~brk;
            8'h14: mods_nx[2] = ~brk;
            8'h11: mods_nx[3] = ~brk;
            8'h58: if (!brk && !repeat_ev) mods_nx[4] = ~mods[4];
            default: mods_nx = mods;
         endcase
      end
   end

   assign push_req = valid_ev & ~repeat_ev & ((MOD_EVENTS != 0) | ~is_mod);

   always_ff @(posedge clk) begin
      if (clr) begin
         state         <= IDLE;
         skip_cnt      <= 3'd0;
         mods          <= 5'd0;
         kb_nextdata_n <= 1'b1;
      end else begin
         state         <= state_nx;
         skip_cnt      <= skip_cnt_nx;
         mods          <= mods_nx;
         kb_nextdata_n <= ~accept;
      end
   end

   assign shift = mods[0] | mods[1];
   assign ctrl  = mods[2];
   assign alt   = mods[3];
   assign caps  = mods[4];

   // Event FIFO: entry = {mods, brk, ext, code}
   logic [14:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, push_ok;

   assign full    = (count == DEPTH[AW:0]);
   assign pop     = ev_rd & (count != '0);
   assign push_ok = push_req & (~full | pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {mods_nx, brk, ext, code};
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && !push_ok) overflow <= 1'b1;
      end
   end

   assign ev_valid = (count != '0);
   assign ev_count = count;
   assign ev_code  = mem[rd_ptr][7:0];
   assign ev_ext   = mem[rd_ptr][8];
   assign ev_brk   = mem[rd_ptr][9];
   assign ev_mods  = mem[rd_ptr][14:10];

endmodule
`default_nettype wire

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
- Parametrised successor to the single-key PS/2 keyboard tracker: decodes the raw scan-code byte stream from the PS/2 receiver into complete key events (make/break, E0-extended, Pause) and queues them in a FIFO for the CPU/terminal side.
- Tracks left/right shift, ctrl, alt and caps-lock live. No key press is lost while a previous one is still held.
- Sits between the existing ps2_keyboard receiver and the bus-side keyboard register / data2ascii path.

Parameters:
- DEPTH, 16, event FIFO entries; power of 2, at least 2.
- MOD_EVENTS, 1, 1 = modifier keys also enqueue events; 0 = modifiers update state only.

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous reset, active-high
- kb_data  in  8  byte from ps2_keyboard data
- kb_ready  in  1  ps2_keyboard ready
- kb_nextdata_n  out  1  to ps2_keyboard nextdata_n; low one cycle = byte consumed
- ev_valid  out  1  FIFO not empty
- ev_code  out  8  head event scan code
- ev_ext  out  1  head event had E0 prefix
- ev_brk  out  1  head event is a release
- ev_mods  out  5  head event modifier snapshot {caps, alt, ctrl, rshift, lshift}
- ev_rd  in  1  pop head event
- ev_count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky: an event was dropped
- shift, ctrl, alt, caps  out  1  live state; shift = lshift | rshift

Behaviour:
- Reset (clr=1 at posedge): FSM=IDLE, FIFO empty, ev_valid=0, ev_count=0, overflow=0, all modifiers 0, kb_nextdata_n=1, skip counter 0. Any partial sequence is discarded.
- Byte accept: occurs in a cycle with kb_ready=1 and kb_nextdata_n=1. kb_nextdata_n is registered low for exactly the next cycle, then returns to 1. No accept while it is low.
- FSM on each accepted byte:
  - IDLE:
    - E0 -> GOT_E0
    - F0 -> GOT_F0
    - E1 -> SKIP, counter=7
    - AA, FA, EE, FE, 00, FF -> ignored, stay IDLE
    - any other byte -> make event (ext=0), go IDLE
  - GOT_E0: F0 -> GOT_E0F0; any other byte -> make event (ext=1), go IDLE.
  - GOT_F0: any byte -> break event (ext=0), go IDLE.
  - GOT_E0F0: any byte -> break event (ext=1), go IDLE.
  - SKIP: decrement counter per byte, regardless of value. When it reaches 0, enqueue one Pause event (code=E1, ext=0, brk=0) and go IDLE.
- Fake shifts: ext events with code 12 or 59 (PrtSc/Num wrappers) are dropped entirely.
- Modifier update (same cycle as event completion):
  - 12 -> lshift; 59 -> rshift; 14 -> ctrl (either ext); 11 -> alt (either ext).
  - Make sets the bit, break clears it.
  - 58 make toggles caps; 58 break has no effect.
- ev_mods: snapshot after this event's own modifier update.
- Event push: registered, so the byte accepted at cycle N is at the head with ev_valid=1 at N+1 when the FIFO was empty.
  - Modifier-key events (12, 59, 14, 11, 58) are pushed only if MOD_EVENTS=1.
  - The live shift/ctrl/alt/caps outputs update at N+1.
- FIFO is first-word-fall-through; ev_* show the head whenever ev_valid=1.
  - ev_rd with ev_valid=1 pops.
  - ev_rd while empty is ignored.
- Full:
  - A push with no pop in the same cycle is dropped, sets overflow, and leaves the FIFO unchanged.
  - Push and pop in the same cycle while full: both happen, count unchanged.
  - Push and pop in the same cycle while empty: pop ignored, push lands.
- Pointers wrap modulo DEPTH. ev_count ranges 0..DEPTH.
- overflow clears only on clr.
- Modifier state is not affected by FIFO fullness.

Optional Feature:
- Macro: KBD_REPEAT_FILTER_EN.
- Defined:
  - Register the last make {ext, code} plus a held flag.
  - A make identical to the held key is typematic repeat: no push, no caps toggle.
  - A break of the held key clears held.
  - A make of a different key replaces the held key.
  - Modifier state updates are idempotent, so they still apply.
- Undefined: every make is pushed. Each 58 make toggles caps.

Test Plan:
- Bytes 1C, F0, 1C -> two events: {1C, ext0, brk0}, {1C, ext0, brk1}; ev_count=2; kb_nextdata_n low one cycle per byte.
- E0 75, E0 F0 75 -> {75, ext1, brk0}, {75, ext1, brk1}. Then E0 12 E0 7C -> only {7C, ext1}, no event for 12.
- 12, 1C, F0 1C, F0 12 with MOD_EVENTS=1:
  - 4 events; the 1C make carries mods=00001, the 12 break carries 00000.
  - Repeat with MOD_EVENTS=0 -> 2 events.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one {E1, ext0, brk0}; ctrl stays 0.
- DEPTH=4, no reads, 5 makes:
  - count=4, overflow=1, head is the first key.
  - Then pop and push in the same cycle -> count stays 4.
  - clr -> count=0, overflow=0.
- With KBD_REPEAT_FILTER_EN: 1C 1C 1C F0 1C -> 2 events; 58 58 F0 58 -> caps=1. Without the macro: 4 events and caps=0 respectively.
